// File: rtl/base_dbus_mux_pkg.sv
// Shared definitions for the base-system data-bus router: region codes and
// the address fields used to decode them.
package base_dbus_mux_pkg;

    typedef enum logic [1:0] {
        REG_DMEM  = 2'b00,
        REG_COLL  = 2'b01,
        REG_TIMER = 2'b10,
        REG_FIFO  = 2'b11
    } region_e;

    localparam int REGION_MSB = 31;
    localparam logic [3:0] SIM_END_NIBBLE = 4'hF;

endpackage

// File: rtl/base_dbus_mux.sv
// Routes SERV data-bus accesses to dmem, collector, timer or FIFO bridge by the
// top two address bits, and generates the ack for slaves that lack one.
module base_dbus_mux
    import base_dbus_mux_pkg::*;
#(
    parameter int sim = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic [31:0] i_wb_dbus_adr,
    input  logic [31:0] i_wb_dbus_dat,
    input  logic [3:0]  i_wb_dbus_sel,
    input  logic        i_wb_dbus_we,
    input  logic        i_wb_dbus_cyc,
    output logic [31:0] o_wb_dbus_rdt,
    output logic        o_wb_dbus_ack,

    output logic [31:0] o_wb_dmem_adr,
    output logic [31:0] o_wb_dmem_dat,
    output logic [3:0]  o_wb_dmem_sel,
    output logic        o_wb_dmem_we,
    output logic        o_wb_dmem_cyc,
    input  logic [31:0] i_wb_dmem_rdt,

    output logic [31:0] o_wb_coll_adr,
    output logic [31:0] o_wb_coll_dat,
    output logic        o_wb_coll_we,
    output logic        o_wb_coll_stb,
    input  logic [31:0] i_wb_coll_rdt,
    input  logic        i_wb_coll_ack,

    output logic [31:0] o_wb_timer_dat,
    output logic        o_wb_timer_we,
    output logic        o_wb_timer_cyc,
    input  logic [31:0] i_wb_timer_rdt,

    output logic [8:0]  o_wb_fifo_dat,
    output logic        o_wb_fifo_we,
    output logic        o_wb_fifo_stb,
    input  logic        i_wb_fifo_ack
);

    region_e region;
    logic    ack_q;
    logic    sel_dmem, sel_coll, sel_timer, sel_fifo;

    assign region    = region_e'(i_wb_dbus_adr[REGION_MSB -: 2]);
    assign sel_dmem  = (region == REG_DMEM);
    assign sel_coll  = (region == REG_COLL);
    assign sel_timer = (region == REG_TIMER);
    assign sel_fifo  = (region == REG_FIFO);

    assign o_wb_dmem_adr  = i_wb_dbus_adr;
    assign o_wb_dmem_dat  = i_wb_dbus_dat;
    assign o_wb_dmem_sel  = i_wb_dbus_sel;
    assign o_wb_dmem_we   = i_wb_dbus_we;
    assign o_wb_dmem_cyc  = i_wb_dbus_cyc & sel_dmem;

    assign o_wb_coll_adr  = i_wb_dbus_adr;
    assign o_wb_coll_dat  = i_wb_dbus_dat;
    assign o_wb_coll_we   = i_wb_dbus_we;
    assign o_wb_coll_stb  = i_wb_dbus_cyc & sel_coll;

    assign o_wb_timer_dat = i_wb_dbus_dat;
    assign o_wb_timer_we  = i_wb_dbus_we;
    assign o_wb_timer_cyc = i_wb_dbus_cyc & sel_timer;

    // Bit 8 carries tlast, bits 7:0 the stream byte.
    assign o_wb_fifo_dat  = i_wb_dbus_dat[8:0];
    assign o_wb_fifo_we   = i_wb_dbus_we;
    assign o_wb_fifo_stb  = i_wb_dbus_cyc & sel_fifo;

    // Single-cycle ack for dmem and timer; the !ack_q term forces a gap cycle
    // so a held cyc cannot produce two consecutive acks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= i_wb_dbus_cyc & (sel_dmem | sel_timer) & ~ack_q;
        end
    end

    assign o_wb_dbus_ack = ack_q
                         | (sel_coll & i_wb_dbus_cyc & i_wb_coll_ack)
                         | (sel_fifo & i_wb_dbus_cyc & i_wb_fifo_ack);

    always_comb begin
        o_wb_dbus_rdt = 32'h0;
        case (region)
            REG_DMEM:  o_wb_dbus_rdt = i_wb_dmem_rdt;
            REG_COLL:  o_wb_dbus_rdt = i_wb_coll_rdt;
            REG_TIMER: o_wb_dbus_rdt = i_wb_timer_rdt;
            default:   o_wb_dbus_rdt = 32'h0;
        endcase
    end

`ifndef SYNTHESIS
    // End-of-test hook; the access itself still reaches the FIFO.
    always @(posedge i_clk) begin
        if (sim != 0 && i_wb_dbus_cyc && i_wb_dbus_we &&
            i_wb_dbus_adr[31:28] == SIM_END_NIBBLE) begin
            $display("end of test");
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_base_dbus_mux.sv
// Directed bench for base_dbus_mux: region decode, pass-throughs, ack timing,
// read-data mux and reset behaviour.
module tb_base_dbus_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dbus_adr, dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we, dbus_cyc;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [31:0] dmem_adr, dmem_dat;
    logic [3:0]  dmem_sel;
    logic        dmem_we, dmem_cyc;
    logic [31:0] dmem_rdt;
    logic [31:0] coll_adr, coll_dat;
    logic        coll_we, coll_stb;
    logic [31:0] coll_rdt;
    logic        coll_ack;
    logic [31:0] timer_dat;
    logic        timer_we, timer_cyc;
    logic [31:0] timer_rdt;
    logic [8:0]  fifo_dat;
    logic        fifo_we, fifo_stb;
    logic        fifo_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    base_dbus_mux #(.sim(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_dbus_adr(dbus_adr), .i_wb_dbus_dat(dbus_dat), .i_wb_dbus_sel(dbus_sel),
        .i_wb_dbus_we(dbus_we), .i_wb_dbus_cyc(dbus_cyc),
        .o_wb_dbus_rdt(dbus_rdt), .o_wb_dbus_ack(dbus_ack),
        .o_wb_dmem_adr(dmem_adr), .o_wb_dmem_dat(dmem_dat), .o_wb_dmem_sel(dmem_sel),
        .o_wb_dmem_we(dmem_we), .o_wb_dmem_cyc(dmem_cyc), .i_wb_dmem_rdt(dmem_rdt),
        .o_wb_coll_adr(coll_adr), .o_wb_coll_dat(coll_dat), .o_wb_coll_we(coll_we),
        .o_wb_coll_stb(coll_stb), .i_wb_coll_rdt(coll_rdt), .i_wb_coll_ack(coll_ack),
        .o_wb_timer_dat(timer_dat), .o_wb_timer_we(timer_we), .o_wb_timer_cyc(timer_cyc),
        .i_wb_timer_rdt(timer_rdt),
        .o_wb_fifo_dat(fifo_dat), .o_wb_fifo_we(fifo_we), .o_wb_fifo_stb(fifo_stb),
        .i_wb_fifo_ack(fifo_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input string tag, input logic [3:0] exp);
        chk(tag, {28'h0, dmem_cyc, coll_stb, timer_cyc, fifo_stb}, {28'h0, exp});
    endtask

    logic [5:0] ack_pat;

    initial begin
        rst_n = 1'b0;
        dbus_adr = 32'h0; dbus_dat = 32'h0; dbus_sel = 4'h0;
        dbus_we = 1'b0; dbus_cyc = 1'b0;
        dmem_rdt = 32'hDEADBEEF; coll_rdt = 32'hAAAA5555;
        timer_rdt = 32'h0000_0100; coll_ack = 1'b0; fifo_ack = 1'b0;

        // DMEM read issued while reset is held
        #1;
        dbus_adr = 32'h0000_0010; dbus_cyc = 1'b1; dbus_sel = 4'hF;
        tick(); tick();
        chk("rst_ack", {31'h0, dbus_ack}, 32'h0);
        strobes("rst_strobes", 4'b1000);
        chk("rst_dmem_adr", dmem_adr, 32'h0000_0010);
        rst_n = 1'b1;
        #1;
        chk("dmem_ack_pre", {31'h0, dbus_ack}, 32'h0);
        tick();
        chk("dmem_ack", {31'h0, dbus_ack}, 32'h1);
        chk("dmem_rdt", dbus_rdt, 32'hDEADBEEF);
        chk("dmem_sel", {28'h0, dmem_sel}, 32'hF);
        dbus_cyc = 1'b0;
        #1;
        strobes("idle_strobes", 4'b0000);
        tick();
        chk("dmem_ack_drop", {31'h0, dbus_ack}, 32'h0);

        // COLL write acked by the slave after 3 cycles
        dbus_adr = 32'h4000_0008; dbus_dat = 32'h1234_5678; dbus_we = 1'b1; dbus_cyc = 1'b1;
        #1;
        strobes("coll_strobes", 4'b0100);
        chk("coll_adr", coll_adr, 32'h4000_0008);
        chk("coll_dat", coll_dat, 32'h1234_5678);
        chk("coll_we", {31'h0, coll_we}, 32'h1);
        tick(); tick();
        chk("coll_ack_wait", {31'h0, dbus_ack}, 32'h0);
        tick();
        coll_ack = 1'b1;
        #1;
        chk("coll_ack", {31'h0, dbus_ack}, 32'h1);
        chk("coll_rdt", dbus_rdt, 32'hAAAA5555);
        coll_ack = 1'b0; dbus_cyc = 1'b0;
        tick();

        // TIMER read then write
        dbus_adr = 32'h8000_0000; dbus_we = 1'b0; dbus_cyc = 1'b1;
        #1;
        strobes("timer_strobes", 4'b0010);
        chk("timer_we_rd", {31'h0, timer_we}, 32'h0);
        chk("timer_ack_pre", {31'h0, dbus_ack}, 32'h0);
        tick();
        chk("timer_ack", {31'h0, dbus_ack}, 32'h1);
        chk("timer_rdt", dbus_rdt, 32'h0000_0100);
        dbus_cyc = 1'b0;
        tick();
        dbus_we = 1'b1; dbus_dat = 32'hCAFE_0001; dbus_cyc = 1'b1;
        #1;
        chk("timer_we_wr", {31'h0, timer_we}, 32'h1);
        chk("timer_dat", timer_dat, 32'hCAFE_0001);
        tick();
        chk("timer_wr_ack", {31'h0, dbus_ack}, 32'h1);
        dbus_cyc = 1'b0;
        tick();

        // FIFO write and read
        dbus_adr = 32'hC000_0000; dbus_dat = 32'h0000_0141; dbus_cyc = 1'b1;
        #1;
        strobes("fifo_strobes", 4'b0001);
        chk("fifo_dat", {23'h0, fifo_dat}, 32'h141);
        chk("fifo_we", {31'h0, fifo_we}, 32'h1);
        tick();
        chk("fifo_ack_wait", {31'h0, dbus_ack}, 32'h0);
        fifo_ack = 1'b1;
        #1;
        chk("fifo_ack", {31'h0, dbus_ack}, 32'h1);
        dbus_we = 1'b0;
        #1;
        chk("fifo_rdt", dbus_rdt, 32'h0);
        fifo_ack = 1'b0; dbus_cyc = 1'b0;
        tick();

        // Back-to-back DMEM with cyc held; foreign acks must be ignored
        dbus_adr = 32'h0000_0100; dbus_cyc = 1'b1; coll_ack = 1'b1; fifo_ack = 1'b1;
        #1;
        chk("b2b_foreign_ack", {31'h0, dbus_ack}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            ack_pat[i] = dbus_ack;
        end
        chk("b2b_pattern", {26'h0, ack_pat}, 32'h0000_0015);
        dbus_cyc = 1'b0; coll_ack = 1'b0; fifo_ack = 1'b0;
        tick();

        // Reset mid-transfer kills the pending ack immediately
        dbus_cyc = 1'b1;
        tick();
        chk("abort_ack_pre", {31'h0, dbus_ack}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_ack", {31'h0, dbus_ack}, 32'h0);
        tick();
        chk("abort_ack_held", {31'h0, dbus_ack}, 32'h0);
        dbus_cyc = 1'b0;
        rst_n = 1'b1;
        tick();

        // End-of-test address with the hook disabled is an ordinary FIFO write
        dbus_adr = 32'hF000_0000; dbus_dat = 32'h0000_01FF; dbus_we = 1'b1; dbus_cyc = 1'b1;
        #1;
        strobes("end_strobes", 4'b0001);
        chk("end_fifo_dat", {23'h0, fifo_dat}, 32'h1FF);
        tick();
        fifo_ack = 1'b1;
        #1;
        chk("end_fifo_ack", {31'h0, dbus_ack}, 32'h1);
        fifo_ack = 1'b0; dbus_cyc = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/base_dbus_mux.md
# base_dbus_mux

Data-bus address decoder and router between the SERV CPU data port and the four base-system slaves: shared data memory (via the ibus/dbus memory arbiter), the external collector bus, the interval timer, and the AXI-Stream output FIFO bridge. It decodes the two top address bits, gates each slave's strobe, and returns the read data and ack to the CPU. It also generates the acks for the slaves that have none: dmem, whose arbiter ack is unused, and timer.

## Interface
- sim, default 0: nonzero enables the simulation-only end-of-test hook; has no effect in synthesis.
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_wb_dbus_adr / _dat  in  32 each  CPU address / write data.
- i_wb_dbus_sel  in  4  byte enables.
- i_wb_dbus_we, i_wb_dbus_cyc  in  1 each  write enable / cycle request.
- o_wb_dbus_rdt  out  32  read data.
- o_wb_dbus_ack  out  1  transfer complete.
- o_wb_dmem_adr / _dat  out  32 each; o_wb_dmem_sel  out  4; o_wb_dmem_we, o_wb_dmem_cyc  out  1 each.
- i_wb_dmem_rdt  in  32  memory read data.
- o_wb_coll_adr / _dat  out  32 each; o_wb_coll_we, o_wb_coll_stb  out  1 each.
- i_wb_coll_rdt  in  32; i_wb_coll_ack  in  1.
- o_wb_timer_dat  out  32; o_wb_timer_we, o_wb_timer_cyc  out  1 each.
- i_wb_timer_rdt  in  32.
- o_wb_fifo_dat  out  9; o_wb_fifo_we, o_wb_fifo_stb  out  1 each.
- i_wb_fifo_ack  in  1.

## Operation
- The region is i_wb_dbus_adr[31:30]:
  - 00 = DMEM
  - 01 = COLL
  - 10 = TIMER
  - 11 = FIFO
- Strobes are cyc AND the region match: o_wb_dmem_cyc, o_wb_coll_stb, o_wb_timer_cyc, o_wb_fifo_stb. Exactly one is high while cyc=1; all are low while cyc=0.
- Pass-throughs, always driven and region-independent:
  - dmem: full adr/dat, sel, we.
  - coll: full adr/dat, we.
  - timer: dat, we.
  - fifo: dat[8:0] (bit 8 = tlast, bits 7:0 = tdata), we.
- Ack source:
  - DMEM and TIMER use internal ack register ack_q, updated each clock as ack_q <= cyc & region∈{DMEM,TIMER} & !ack_q.
  - COLL uses i_wb_coll_ack combinationally; FIFO uses i_wb_fifo_ack combinationally.
  - o_wb_dbus_ack = ack_q | (COLL & cyc & i_wb_coll_ack) | (FIFO & cyc & i_wb_fifo_ack).
- Read data mux, combinational by region:
  - DMEM → i_wb_dmem_rdt
  - COLL → i_wb_coll_rdt
  - TIMER → i_wb_timer_rdt
  - FIFO → 32'h0
- Acks from non-selected slaves are ignored.
- sim≠0: a write (cyc & we) with adr[31:28]=4'hF prints "end of test" and calls $finish in simulation. The access is still forwarded to the FIFO as normal. This hook is translate_off.

## Timing
- Everything is combinational except ack_q.
- Reset: ack_q = 0, so o_wb_dbus_ack = 0 while reset is asserted (given the slave acks are 0). The other outputs follow their inputs.
- DMEM/TIMER: ack one cycle after cyc rises. The memory's registered rdt is valid in that same ack cycle.
- The CPU must drop cyc after ack. The !ack_q term makes the next transfer's ack arrive no sooner than two cycles later.
- COLL/FIFO latency equals the slave's own ack latency, zero cycles added. A slave that never acks stalls the CPU indefinitely; there is no timeout.
- Reset asserted mid-transfer clears ack_q immediately. No ack is emitted for the aborted transfer.
- Region change while cyc is high is illegal (Wishbone holds adr stable); behaviour is unspecified.

## Structure
- Shared package holds:
  - REG_DMEM=2'b00, REG_COLL=2'b01, REG_TIMER=2'b10, REG_FIFO=2'b11
  - REGION_MSB=31
  - SIM_END_NIBBLE=4'hF
- Single module; no sub-module is natural, since the ack register is one flop.

## Test plan
- Reset low, cyc=1 to 0x0000_0010 → ack=0 while in reset. Release → o_wb_dmem_cyc=1 and ack one cycle later with rdt=i_wb_dmem_rdt (e.g. 0xDEADBEEF).
- Write 0x4000_0008 dat=0x1234_5678, coll acks after 3 cycles → coll_stb=1, coll_adr/dat match, dbus_ack in the same cycle as i_wb_coll_ack.
- Read 0x8000_0000 with timer_rdt=0x0000_0100 → timer_cyc=1, we=0, ack after 1 cycle, rdt=0x100. Write → timer_we=1.
- Write 0xC000_0000 dat=0x0000_0141 → fifo_dat=9'h141, stb=1, ack follows i_wb_fifo_ack. A read returns 0.
- Back-to-back DMEM accesses with cyc held high → ack pulses exactly one cycle each, never two consecutive cycles.
- sim=1, write 0xF000_0000 → simulation ends. With sim=0, the same write just completes as a FIFO write.
